// File: rtl/bus_size_sequencer.sv
// bus_size_sequencer
//   Breaks one 68030-style access (byte offset, size, direction) on a 32-bit
//   big-endian bus into one or more beats on a narrower downstream port.
//   Each beat drives an address, byte enables and a strobe, and waits for an
//   acknowledge. A per-beat timeout aborts the rest of the access.
//
// Ports
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   req    in   start strobe, sampled only while idle
//   a      in   CPU byte offset within the long word
//   siz    in   transfer size (01=1, 10=2, 11=3, 00=4 bytes)
//   wr     in   write (1) / read (0), latched with req
//   ack    in   port acknowledge for the current beat
//   busy   out  access in progress
//   b      out  latched CPU lane mask, b[3] = offset 0 ... b[0] = offset 3
//   pa     out  beat byte offset (chunk * PORT_BYTES)
//   pbe    out  port byte enables, MSB = lowest offset in the chunk
//   blane  out  CPU lanes served by the current beat
//   pstb   out  beat strobe
//   pwr    out  latched direction
//   done   out  one-cycle completion pulse
//   err    out  valid with done, 1 = aborted by timeout
module bus_size_sequencer #(
  parameter int PORT_BYTES = 4,
  parameter int TMO_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [1:0]            a,
  input  logic [1:0]            siz,
  input  logic                  wr,
  input  logic                  ack,
  output logic                  busy,
  output logic [3:0]            b,
  output logic [1:0]            pa,
  output logic [PORT_BYTES-1:0] pbe,
  output logic [3:0]            blane,
  output logic                  pstb,
  output logic                  pwr,
  output logic                  done,
  output logic                  err
);

  // log2 of the port width; chunk index <-> byte offset conversion
  localparam int SHIFT = (PORT_BYTES == 4) ? 2 : ((PORT_BYTES == 2) ? 1 : 0);
  // lane window of chunk 0; shifted right by the beat offset for later chunks
  localparam logic [3:0] WIN_TOP = 4'(4'b1111 << (4 - PORT_BYTES));
  // counter value seen on the last permitted strobe cycle of a beat
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
  localparam bit TMO_EN = (TMO_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BEAT = 2'b01,
    ST_GAP  = 2'b10,
    ST_FIN  = 2'b11
  } state_t;

  // Highest offset touched by the access; bytes beyond offset 3 are left to
  // the CPU's follow-up cycle, so the result saturates at 3.
  function automatic logic [1:0] last_offset(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] sum;
    // size-1 in two bits: 00 (four bytes) wraps to 3
    sum = {1'b0, off} + {1'b0, 2'(sz - 2'd1)};
    if (sum > 3'd3) begin
      sum = 3'd3;
    end else begin
      sum = sum;
    end
    return sum[1:0];
  endfunction

  // Lane mask with the bit for offset k at position 3-k.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] sz);
    logic [1:0] hi;
    logic [3:0] m;
    hi = last_offset(off, sz);
    m  = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      m[3-k] = (2'(k) >= off) && (2'(k) <= hi);
    end
    return m;
  endfunction

  state_t      state_r, state_nx_s;
  logic [1:0]  chunk_r, chunk_nx_s;
  logic [1:0]  last_chunk_r, last_chunk_nx_s;
  logic [7:0]  tmo_cnt_r;
  logic        tmo_hit_s;
  logic [3:0]  b_nx_s;
  logic        pwr_nx_s;

  logic        busy_s, pstb_s, done_s, err_s;
  logic [1:0]  pa_s;
  logic [3:0]  lanes_s;
  logic [PORT_BYTES-1:0] pbe_s;
  logic [3:0]  blane_s;

  // State register and access context (chunk pointer, last chunk, timeout counter)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      chunk_r      <= 2'd0;
      last_chunk_r <= 2'd0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      state_r      <= state_nx_s;
      chunk_r      <= chunk_nx_s;
      last_chunk_r <= last_chunk_nx_s;
      if ((state_nx_s == ST_BEAT) && (state_r != ST_BEAT)) begin
        tmo_cnt_r <= 8'd0;
      end else if ((state_r == ST_BEAT) && !ack) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

  // Next-state logic: request acceptance, beat advance and timeout abort
  always_comb begin
    state_nx_s      = state_r;
    chunk_nx_s      = chunk_r;
    last_chunk_nx_s = last_chunk_r;
    b_nx_s          = b;
    pwr_nx_s        = pwr;
    tmo_hit_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_nx_s      = ST_BEAT;
          chunk_nx_s      = 2'(a >> SHIFT);
          last_chunk_nx_s = 2'(last_offset(a, siz) >> SHIFT);
          b_nx_s          = lane_mask(a, siz);
          pwr_nx_s        = wr;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BEAT: begin
        // an ack on the final permitted cycle still counts as a normal beat
        tmo_hit_s = TMO_EN && (tmo_cnt_r == TMO_LAST) && !ack;
        if (ack) begin
          if (chunk_r == last_chunk_r) begin
            state_nx_s = ST_FIN;
          end else begin
            state_nx_s = ST_GAP;
            chunk_nx_s = 2'(chunk_r + 2'd1);
          end
        end else if (tmo_hit_s) begin
          state_nx_s = ST_FIN;
        end else begin
          state_nx_s = ST_BEAT;
        end
      end
      ST_GAP: begin
        state_nx_s = ST_BEAT;
      end
      ST_FIN: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    busy_s  = (state_nx_s != ST_IDLE);
    pstb_s  = (state_nx_s == ST_BEAT);
    done_s  = (state_nx_s == ST_FIN);
    err_s   = (state_nx_s == ST_FIN) && tmo_hit_s;
    pa_s    = 2'd0;
    lanes_s = 4'b0000;
    pbe_s   = '0;
    blane_s = 4'b0000;
    if (state_nx_s == ST_BEAT) begin
      pa_s    = 2'(chunk_nx_s << SHIFT);
      // bring the chunk's lanes to the top so the MSB is its lowest offset
      lanes_s = 4'(b_nx_s << pa_s);
      pbe_s   = lanes_s[3 -: PORT_BYTES];
      blane_s = b_nx_s & (WIN_TOP >> pa_s);
    end else begin
      pa_s    = 2'd0;
      lanes_s = 4'b0000;
      pbe_s   = '0;
      blane_s = 4'b0000;
    end
  end

  // Output registers; async reset drops the strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      pstb  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      pwr   <= 1'b0;
      b     <= 4'b0000;
      pa    <= 2'd0;
      pbe   <= '0;
      blane <= 4'b0000;
    end else begin
      busy  <= busy_s;
      pstb  <= pstb_s;
      done  <= done_s;
      err   <= err_s;
      pwr   <= pwr_nx_s;
      b     <= b_nx_s;
      pa    <= pa_s;
      pbe   <= pbe_s;
      blane <= blane_s;
    end
  end

endmodule

// File: tb/tb_bus_size_sequencer.sv
// tb_bus_size_sequencer
//   Runs three sequencers (1-, 2- and 4-byte ports, timeout of 8 cycles) off
//   the same CPU-side stimulus. A reference model queues the expected beats
//   and completion of every accepted access per instance; a negedge monitor
//   pops and compares them as the instances produce strobes and done pulses.
module tb_bus_size_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] a, siz;
  logic       wr;
  logic       ack1 = 1'b0, ack2 = 1'b0, ack4 = 1'b0;

  logic       busy1, pstb1, pwr1, done1, err1;
  logic [3:0] b1, blane1;
  logic [1:0] pa1;
  logic [0:0] pbe1;
  logic       busy2, pstb2, pwr2, done2, err2;
  logic [3:0] b2, blane2;
  logic [1:0] pa2;
  logic [1:0] pbe2;
  logic       busy4, pstb4, pwr4, done4, err4;
  logic [3:0] b4, blane4;
  logic [1:0] pa4;
  logic [3:0] pbe4;

  always #5 clk = ~clk;

  bus_size_sequencer #(.PORT_BYTES(1), .TMO_CYCLES(8)) u_p1 (
    .clk(clk), .rst(rst), .req(req), .a(a), .siz(siz), .wr(wr), .ack(ack1),
    .busy(busy1), .b(b1), .pa(pa1), .pbe(pbe1), .blane(blane1), .pstb(pstb1),
    .pwr(pwr1), .done(done1), .err(err1));

  bus_size_sequencer #(.PORT_BYTES(2), .TMO_CYCLES(8)) u_p2 (
    .clk(clk), .rst(rst), .req(req), .a(a), .siz(siz), .wr(wr), .ack(ack2),
    .busy(busy2), .b(b2), .pa(pa2), .pbe(pbe2), .blane(blane2), .pstb(pstb2),
    .pwr(pwr2), .done(done2), .err(err2));

  bus_size_sequencer #(.PORT_BYTES(4), .TMO_CYCLES(8)) u_p4 (
    .clk(clk), .rst(rst), .req(req), .a(a), .siz(siz), .wr(wr), .ack(ack4),
    .busy(busy4), .b(b4), .pa(pa4), .pbe(pbe4), .blane(blane4), .pstb(pstb4),
    .pwr(pwr4), .done(done4), .err(err4));

  typedef struct {
    bit         fin;
    logic [1:0] pa;
    logic [3:0] pbe;
    logic [3:0] blane;
    logic       pwr;
    logic       err;
    logic [3:0] b;
    int         len;
  } exp_t;

  exp_t q1[$], q2[$], q4[$];

  int checks = 0;
  int errors = 0;

  int ack_delay = 1;   // strobe cycle on which ack is given, 0 = never
  bit noise = 1'b0;    // random ack while no strobe is up

  // per-instance monitor state
  bit   prev_pstb[3];
  bit   prev_done[3];
  int   slen[3];
  int   glen[3];
  int   nbeats[3];
  exp_t cur[3];
  int   w1 = 0, w2 = 0, w4 = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0:       q1.push_back(e);
      1:       q2.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic qpop(input int id, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: 0};
    case (id)
      0:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      1:       if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q4.size() > 0) begin e = q4.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Reference model: beats and completion for one access on every port width.
  task automatic push_access(input logic [1:0] ta, input logic [1:0] tsiz,
                             input logic twr, input int tdelay);
    for (int id = 0; id < 3; id++) begin
      int pb, n, blen;
      bit timed, any;
      logic [3:0] mask, pbe, bl;
      exp_t e;
      pb    = 1 << id;
      n     = (tsiz == 2'b00) ? 4 : int'(tsiz);
      timed = (tdelay == 0) || (tdelay > 8);
      blen  = timed ? 8 : tdelay;
      mask  = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if ((k >= int'(ta)) && (k <= int'(ta) + n - 1)) mask[3-k] = 1'b1;
      end
      for (int c = 0; c < 4 / pb; c++) begin
        any = 1'b0;
        pbe = 4'b0000;
        bl  = 4'b0000;
        for (int j = 0; j < pb; j++) begin
          if (mask[3-(c*pb+j)]) begin
            any = 1'b1;
            pbe[pb-1-j] = 1'b1;
            bl[3-(c*pb+j)] = 1'b1;
          end
        end
        if (any) begin
          e = '{fin: 1'b0, pa: 2'(c*pb), pbe: pbe, blane: bl, pwr: twr,
                err: 1'b0, b: mask, len: blen};
          qpush(id, e);
          if (timed) break;
        end
      end
      e = '{fin: 1'b1, pa: 2'd0, pbe: 4'b0000, blane: 4'b0000, pwr: twr,
            err: timed, b: mask, len: 0};
      qpush(id, e);
    end
  endtask

  task automatic mon(input int id, input logic busy_v, input logic pstb_v,
                     input logic done_v, input logic err_v, input logic pwr_v,
                     input logic [1:0] pa_v, input logic [3:0] pbe_v,
                     input logic [3:0] blane_v, input logic [3:0] b_v);
    exp_t e;
    bit ok;
    string p;
    p = $sformatf("u%0d.", id);
    if (pstb_v && !prev_pstb[id]) begin
      qpop(id, e, ok);
      if (!ok || e.fin) begin
        check_eq({p, "unexpected_beat"}, 1, 0);
      end else begin
        cur[id] = e;
        check_eq({p, "pa"}, int'(pa_v), int'(e.pa));
        check_eq({p, "pbe"}, int'(pbe_v), int'(e.pbe));
        check_eq({p, "blane"}, int'(blane_v), int'(e.blane));
        check_eq({p, "pwr"}, int'(pwr_v), int'(e.pwr));
        if (nbeats[id] > 0) check_eq({p, "gap_len"}, glen[id], 1);
        nbeats[id]++;
      end
      slen[id] = 1;
    end else if (pstb_v) begin
      slen[id]++;
      check_eq({p, "pa_stable"}, int'(pa_v), int'(cur[id].pa));
      check_eq({p, "pbe_stable"}, int'(pbe_v), int'(cur[id].pbe));
      check_eq({p, "blane_stable"}, int'(blane_v), int'(cur[id].blane));
    end else if (prev_pstb[id]) begin
      check_eq({p, "strobe_len"}, slen[id], cur[id].len);
      glen[id] = 1;
    end else begin
      glen[id]++;
    end
    if (done_v) begin
      check_eq({p, "done_pulse"}, int'(prev_done[id]), 0);
      check_eq({p, "busy_in_fin"}, int'(busy_v), 1);
      qpop(id, e, ok);
      if (!ok || !e.fin) begin
        check_eq({p, "unexpected_done"}, 1, 0);
      end else begin
        check_eq({p, "err"}, int'(err_v), int'(e.err));
        check_eq({p, "b"}, int'(b_v), int'(e.b));
      end
      nbeats[id] = 0;
    end else if (err_v) begin
      check_eq({p, "err_without_done"}, 1, 0);
    end
    prev_pstb[id] = pstb_v;
    prev_done[id] = done_v;
  endtask

  // Scoreboard monitor, sampling on the inactive edge
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        prev_pstb[i] = 1'b0;
        prev_done[i] = 1'b0;
        slen[i] = 0;
        glen[i] = 0;
        nbeats[i] = 0;
      end
    end else begin
      mon(0, busy1, pstb1, done1, err1, pwr1, pa1, {3'b000, pbe1}, blane1, b1);
      mon(1, busy2, pstb2, done2, err2, pwr2, pa2, {2'b00, pbe2}, blane2, b2);
      mon(2, busy4, pstb4, done4, err4, pwr4, pa4, pbe4, blane4, b4);
    end
  end

  // Port-side responders: ack on the chosen strobe cycle
  always @(negedge clk) begin
    if (pstb1) begin w1++; ack1 = (ack_delay != 0) && (w1 == ack_delay); end
    else begin w1 = 0; ack1 = noise ? 1'($urandom_range(0, 1)) : 1'b0; end
    if (pstb2) begin w2++; ack2 = (ack_delay != 0) && (w2 == ack_delay); end
    else begin w2 = 0; ack2 = noise ? 1'($urandom_range(0, 1)) : 1'b0; end
    if (pstb4) begin w4++; ack4 = (ack_delay != 0) && (w4 == ack_delay); end
    else begin w4 = 0; ack4 = noise ? 1'($urandom_range(0, 1)) : 1'b0; end
  end

  // One access; while all instances are busy, req is re-asserted with junk
  // operands, which must be ignored.
  task automatic run_access(input logic [1:0] ta, input logic [1:0] tsiz,
                            input logic twr, input int tdelay, input bit tnoise,
                            input bit lat);
    int cyc;
    @(negedge clk);
    a = ta; siz = tsiz; wr = twr; ack_delay = tdelay; noise = tnoise; req = 1'b1;
    push_access(ta, tsiz, twr, tdelay);
    if (lat) begin
      @(negedge clk);
      check_eq("lat.pstb_cycle1", int'(pstb4), 1);
      check_eq("lat.busy_cycle1", int'(busy4), 1);
      @(negedge clk);
      check_eq("lat.done_cycle2", int'(done4), 1);
      check_eq("lat.err_cycle2", int'(err4), 0);
      check_eq("lat.pwr", int'(pwr4), int'(twr));
    end
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!busy1 && !busy2 && !busy4) break;
      req = busy1 && busy2 && busy4;
      a = 2'($urandom); siz = 2'($urandom); wr = 1'($urandom);
    end
    req = 1'b0;
    check_eq("access_in_budget", (cyc < 400) ? 1 : 0, 1);
    @(negedge clk);
    check_eq("q1_drained", q1.size(), 0);
    check_eq("q2_drained", q2.size(), 0);
    check_eq("q4_drained", q4.size(), 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; a = 2'd0; siz = 2'd0; wr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.busy", int'({busy1, busy2, busy4}), 0);
    check_eq("rst.pstb", int'({pstb1, pstb2, pstb4}), 0);
    check_eq("rst.done_err", int'({done1, done2, done4, err1, err2, err4}), 0);
    check_eq("rst.pwr", int'({pwr1, pwr2, pwr4}), 0);
    check_eq("rst.b", int'({b1, b2, b4}), 0);
    check_eq("rst.blane", int'({blane1, blane2, blane4}), 0);
    check_eq("rst.pa", int'({pa1, pa2, pa4}), 0);
    check_eq("rst.pbe", int'({pbe1, pbe2, pbe4}), 0);
    #1 rst = 1'b0;

    run_access(2'b01, 2'b00, 1'b0, 1, 1'b0, 1'b0);  // three narrow beats
    run_access(2'b01, 2'b10, 1'b1, 1, 1'b1, 1'b0);  // split word, ack noise in gaps
    run_access(2'b00, 2'b00, 1'b1, 1, 1'b0, 1'b1);  // full long word, latency
    run_access(2'b11, 2'b11, 1'b0, 2, 1'b0, 1'b0);  // truncated to last byte
    run_access(2'b10, 2'b01, 1'b1, 3, 1'b1, 1'b0);
    run_access(2'b00, 2'b00, 1'b1, 0, 1'b0, 1'b0);  // no ack: timeout abort
    run_access(2'b00, 2'b00, 1'b0, 8, 1'b0, 1'b0);  // ack on the last allowed cycle

    // asynchronous reset in the middle of a beat
    @(negedge clk);
    a = 2'b00; siz = 2'b00; wr = 1'b1; ack_delay = 0; noise = 1'b0; req = 1'b1;
    push_access(2'b00, 2'b00, 1'b1, 0);
    @(negedge clk);
    req = 1'b0;
    check_eq("mid.pstb_before_rst", int'(pstb1 & pstb2 & pstb4), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid.pstb1", int'(pstb1), 0);
    check_eq("mid.pstb2", int'(pstb2), 0);
    check_eq("mid.pstb4", int'(pstb4), 0);
    check_eq("mid.busy", int'(busy1 | busy2 | busy4), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    q1.delete(); q2.delete(); q4.delete();
    ack_delay = 1;

    run_access(2'b01, 2'b11, 1'b1, 1, 1'b0, 1'b0);
    repeat (6) begin
      run_access(2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(1, 3),
                 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
